// File: rtl/arith_arbiter_if.sv
// Bundles both requester channels, the shared datapath hookup and the response
// channel of arith_arbiter; slave is the arbiter side, master is the environment.
interface arith_arbiter_if #(
   parameter int WIDTH = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [1:0]       req0_op;
   logic [WIDTH-1:0] req0_num1;
   logic [WIDTH-1:0] req0_num2;

   logic             req1_valid;
   logic             req1_ready;
   logic [1:0]       req1_op;
   logic [WIDTH-1:0] req1_num1;
   logic [WIDTH-1:0] req1_num2;

   logic [1:0]       dp_op;
   logic [WIDTH-1:0] dp_num1;
   logic [WIDTH-1:0] dp_num2;
   logic [WIDTH-1:0] dp_result;
   logic             dp_overflow;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_overflow;

   logic             busy;
   logic [15:0]      grant_cnt0;
   logic [15:0]      grant_cnt1;
   logic [15:0]      ovf_cnt;

   modport slave (
      input  req0_valid, req0_op, req0_num1, req0_num2,
      input  req1_valid, req1_op, req1_num1, req1_num2,
      input  dp_result, dp_overflow, rsp_ready,
      output req0_ready, req1_ready,
      output dp_op, dp_num1, dp_num2,
      output rsp_valid, rsp_id, rsp_result, rsp_overflow,
      output busy, grant_cnt0, grant_cnt1, ovf_cnt
   );

   modport master (
      output req0_valid, req0_op, req0_num1, req0_num2,
      output req1_valid, req1_op, req1_num1, req1_num2,
      output dp_result, dp_overflow, rsp_ready,
      input  req0_ready, req1_ready,
      input  dp_op, dp_num1, dp_num2,
      input  rsp_valid, rsp_id, rsp_result, rsp_overflow,
      input  busy, grant_cnt0, grant_cnt1, ovf_cnt
   );
endinterface

// File: rtl/arith_arbiter.sv
// Round-robin arbiter sharing one multicycle add/mult datapath between two requesters.
// Define ARB_STATS_EN to build the saturating grant/overflow statistics counters.
module arith_arbiter #(
   parameter int SETTLE_CYCLES = 2,
   parameter int WIDTH         = 16
) (
   input logic            clk,
   input logic            rst,
   arith_arbiter_if.slave bus
);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [1:0]       dp_op_q, dp_op_d;
   logic [WIDTH-1:0] dp_num1_q, dp_num1_d;
   logic [WIDTH-1:0] dp_num2_q, dp_num2_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_overflow_q, rsp_overflow_d;
   logic             rsp_id_q, rsp_id_d;
   logic             rsp_valid_q, rsp_valid_d;

   logic             grant0;
   logic             grant1;
   logic             accept;
   logic             rsp_fire;

   // Grant is not locked: it is recomputed every cycle from the live valids.
   always_comb begin
      grant0   = bus.req0_valid & (~bus.req1_valid | last_grant_q);
      grant1   = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
      accept   = (state_q == IDLE) & (grant0 | grant1);
      rsp_fire = rsp_valid_q & bus.rsp_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    if (cnt_q == 4'd0) state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req0_ready = (state_q == IDLE) & grant0;
      bus.req1_ready = (state_q == IDLE) & grant1;
      bus.busy       = (state_q != IDLE);
   end

   always_comb begin
      last_grant_d   = last_grant_q;
      cnt_d          = cnt_q;
      dp_op_d        = dp_op_q;
      dp_num1_d      = dp_num1_q;
      dp_num2_d      = dp_num2_q;
      rsp_result_d   = rsp_result_q;
      rsp_overflow_d = rsp_overflow_q;
      rsp_id_d       = rsp_id_q;
      rsp_valid_d    = rsp_valid_q;

      if (accept) begin
         dp_op_d      = grant1 ? bus.req1_op   : bus.req0_op;
         dp_num1_d    = grant1 ? bus.req1_num1 : bus.req0_num1;
         dp_num2_d    = grant1 ? bus.req1_num2 : bus.req0_num2;
         rsp_id_d     = grant1;
         last_grant_d = grant1;
         cnt_d        = SETTLE_LOAD;
      end else if (state_q == EXEC) begin
         // Sample the datapath only once the full settle window has elapsed.
         if (cnt_q == 4'd0) begin
            rsp_result_d   = bus.dp_result;
            rsp_overflow_d = bus.dp_overflow;
            rsp_valid_d    = 1'b1;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end else if (rsp_fire) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q   <= 1'b1;
         cnt_q          <= 4'd0;
         dp_op_q        <= 2'd0;
         dp_num1_q      <= '0;
         dp_num2_q      <= '0;
         rsp_result_q   <= '0;
         rsp_overflow_q <= 1'b0;
         rsp_id_q       <= 1'b0;
         rsp_valid_q    <= 1'b0;
      end else begin
         last_grant_q   <= last_grant_d;
         cnt_q          <= cnt_d;
         dp_op_q        <= dp_op_d;
         dp_num1_q      <= dp_num1_d;
         dp_num2_q      <= dp_num2_d;
         rsp_result_q   <= rsp_result_d;
         rsp_overflow_q <= rsp_overflow_d;
         rsp_id_q       <= rsp_id_d;
         rsp_valid_q    <= rsp_valid_d;
      end
   end

   assign bus.dp_op        = dp_op_q;
   assign bus.dp_num1      = dp_num1_q;
   assign bus.dp_num2      = dp_num2_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_result   = rsp_result_q;
   assign bus.rsp_overflow = rsp_overflow_q;

`ifdef ARB_STATS_EN
   logic [1:0]  grant_fire;
   logic        ovf_fire;
   logic [15:0] ovf_cnt_q, ovf_cnt_d;

   assign grant_fire = {accept & grant1, accept & grant0};
   assign ovf_fire   = rsp_fire & rsp_overflow_q;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_grant_cnt
         logic [15:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (grant_fire[gi] && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_q <= 16'd0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (ovf_fire && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_cnt_q <= 16'd0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign bus.grant_cnt0 = g_grant_cnt[0].cnt_q;
   assign bus.grant_cnt1 = g_grant_cnt[1].cnt_q;
   assign bus.ovf_cnt    = ovf_cnt_q;
`else
   assign bus.grant_cnt0 = 16'd0;
   assign bus.grant_cnt1 = 16'd0;
   assign bus.ovf_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_arith_arbiter.sv
// Directed bench for arith_arbiter: three instances (settle 2, 1 and 15) with a
// behavioural datapath stub; every check is an immediate assertion.
module tb_arith_arbiter;
   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

`ifdef ARB_STATS_EN
   localparam logic [15:0] STAT_ONE = 16'd1;
`else
   localparam logic [15:0] STAT_ONE = 16'd0;
`endif

   arith_arbiter_if #(.WIDTH(16)) vif0 ();
   arith_arbiter_if #(.WIDTH(16)) vif1 ();
   arith_arbiter_if #(.WIDTH(16)) vif15 ();

   arith_arbiter #(.SETTLE_CYCLES(2), .WIDTH(16)) u_dut0 (
      .clk(clk), .rst(rst_n), .bus(vif0.slave));
   arith_arbiter #(.SETTLE_CYCLES(1), .WIDTH(16)) u_dut1 (
      .clk(clk), .rst(rst_n), .bus(vif1.slave));
   arith_arbiter #(.SETTLE_CYCLES(15), .WIDTH(16)) u_dut15 (
      .clk(clk), .rst(rst_n), .bus(vif15.slave));

   // Stub datapath: {overflow, result} from the registered opcode/operands.
   function automatic logic [16:0] dp_model(input logic [1:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
      logic [16:0] s;
      logic [31:0] p;
      s = {1'b0, a} + {1'b0, b};
      p = a * b;
      case (op)
         2'b00:   dp_model = {1'b0, ((a == 16'h3C00) && (b == 16'h3C00)) ? 16'h4000 : (a ^ b)};
         2'b01:   dp_model = {1'b0, a & b};
         2'b10:   dp_model = s;
         default: dp_model = {|p[31:16], p[15:0]};
      endcase
   endfunction

   assign {vif0.dp_overflow, vif0.dp_result}   = dp_model(vif0.dp_op, vif0.dp_num1, vif0.dp_num2);
   assign {vif1.dp_overflow, vif1.dp_result}   = dp_model(vif1.dp_op, vif1.dp_num1, vif1.dp_num2);
   assign {vif15.dp_overflow, vif15.dp_result} = dp_model(vif15.dp_op, vif15.dp_num1, vif15.dp_num2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(output int who);
      who = -1;
      for (int i = 0; i < 20 && who < 0; i++) begin
         @(negedge clk);
         if (vif0.req0_ready || vif0.req1_ready) begin
            chk("one_ready", 32'(vif0.req0_ready & vif0.req1_ready), 32'd0);
            who = vif0.req1_ready ? 1 : 0;
         end
      end
      if (who < 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL grant_timeout: observed no ready, expected a ready within 20 cycles");
      end
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!vif0.rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("rsp_valid_seen", 32'(vif0.rsp_valid), 32'd1);
   endtask

   // Present one request, wait for it to be accepted, then count edges
   // (accept edge included) until rsp_valid rises.
   task automatic issue(input int idx, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, output int lat);
      int who;
      int extra;
      if (idx == 0) begin
         vif0.req0_op = op; vif0.req0_num1 = a; vif0.req0_num2 = b; vif0.req0_valid = 1'b1;
      end else begin
         vif0.req1_op = op; vif0.req1_num1 = a; vif0.req1_num2 = b; vif0.req1_valid = 1'b1;
      end
      wait_grant(who);
      chk("grant_id", 32'(who), 32'(idx));
      @(posedge clk); #1;
      if (idx == 0) vif0.req0_valid = 1'b0;
      else          vif0.req1_valid = 1'b0;
      chk("ready_after_accept", {30'd0, vif0.req1_ready, vif0.req0_ready}, 32'd0);
      chk("busy_in_exec", 32'(vif0.busy), 32'd1);
      wait_rsp(extra);
      lat = extra + 1;
   endtask

   task automatic respond();
      vif0.rsp_ready = 1'b1;
      @(posedge clk); #1;
      vif0.rsp_ready = 1'b0;
      chk("rsp_valid_after_hs", 32'(vif0.rsp_valid), 32'd0);
      chk("busy_after_hs", 32'(vif0.busy), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int lat;
      int who;
      int n;
      int lat1;
      int lat15;
      logic saw;

      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      {vif0.req0_valid, vif0.req1_valid, vif0.rsp_ready}    = '0;
      {vif1.req0_valid, vif1.req1_valid, vif1.rsp_ready}    = '0;
      {vif15.req0_valid, vif15.req1_valid, vif15.rsp_ready} = '0;
      {vif0.req0_op, vif0.req0_num1, vif0.req0_num2}    = '0;
      {vif0.req1_op, vif0.req1_num1, vif0.req1_num2}    = '0;
      {vif1.req0_op, vif1.req0_num1, vif1.req0_num2}    = '0;
      {vif1.req1_op, vif1.req1_num1, vif1.req1_num2}    = '0;
      {vif15.req0_op, vif15.req0_num1, vif15.req0_num2} = '0;
      {vif15.req1_op, vif15.req1_num1, vif15.req1_num2} = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(vif0.busy), 32'd0);
      chk("rst_rsp_valid", 32'(vif0.rsp_valid), 32'd0);
      chk("rst_dp_op", 32'(vif0.dp_op), 32'd0);
      chk("rst_dp_num1", 32'(vif0.dp_num1), 32'd0);
      chk("rst_dp_num2", 32'(vif0.dp_num2), 32'd0);
      chk("rst_rsp_result", 32'(vif0.rsp_result), 32'd0);
      chk("rst_rsp_id", 32'(vif0.rsp_id), 32'd0);
      chk("rst_grant_cnt0", 32'(vif0.grant_cnt0), 32'd0);
      chk("rst_ovf_cnt", 32'(vif0.ovf_cnt), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single float add, 1.0 + 1.0
      issue(0, 2'b00, 16'h3C00, 16'h3C00, lat);
      chk("t1_latency", 32'(lat), 32'd3);
      chk("t1_rsp_id", 32'(vif0.rsp_id), 32'd0);
      chk("t1_rsp_result", 32'(vif0.rsp_result), 32'h4000);
      chk("t1_rsp_overflow", 32'(vif0.rsp_overflow), 32'd0);
      respond();
      chk("t1_dp_num1_kept", 32'(vif0.dp_num1), 32'h3C00);

      // Both requesters valid from reset: grants alternate 0,1,0
      do_reset();
      vif0.rsp_ready = 1'b1;
      vif0.req0_op = 2'b10; vif0.req0_num1 = 16'h0001; vif0.req0_num2 = 16'h0002;
      vif0.req1_op = 2'b10; vif0.req1_num1 = 16'h0010; vif0.req1_num2 = 16'h0020;
      vif0.req0_valid = 1'b1;
      vif0.req1_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_grant(who);
         chk("t2_grant_order", 32'(who), 32'(k % 2));
         @(posedge clk); #1;
         if (k == 2) begin
            vif0.req0_valid = 1'b0;
            vif0.req1_valid = 1'b0;
         end
         wait_rsp(lat);
         chk("t2_rsp_id", 32'(vif0.rsp_id), 32'(k % 2));
         chk("t2_rsp_result", 32'(vif0.rsp_result), (k % 2 == 1) ? 32'h0030 : 32'h0003);
      end
      @(posedge clk); #1;
      vif0.rsp_ready = 1'b0;
      chk("t2_idle", 32'(vif0.busy), 32'd0);

      // Backpressure with requester 1 waiting
      issue(0, 2'b10, 16'h0100, 16'h0200, lat);
      vif0.req1_op = 2'b01; vif0.req1_num1 = 16'h00F0; vif0.req1_num2 = 16'h0FF0;
      vif0.req1_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("t3_rsp_valid_held", 32'(vif0.rsp_valid), 32'd1);
         chk("t3_rsp_result_held", 32'(vif0.rsp_result), 32'h0300);
         chk("t3_req1_blocked", 32'(vif0.req1_ready), 32'd0);
      end
      @(posedge clk); #1;
      vif0.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t3_req1_blocked_hs", 32'(vif0.req1_ready), 32'd0);
      @(posedge clk); #1;
      vif0.rsp_ready = 1'b0;
      @(negedge clk);
      chk("t3_req1_accept_next", 32'(vif0.req1_ready), 32'd1);
      @(posedge clk); #1;
      vif0.req1_valid = 1'b0;
      wait_rsp(lat);
      chk("t3_rsp_id", 32'(vif0.rsp_id), 32'd1);
      chk("t3_rsp_result", 32'(vif0.rsp_result), 32'h00F0);
      respond();

      // Fixed mult overflow
      do_reset();
      issue(0, 2'b11, 16'h7FFF, 16'h7FFF, lat);
      chk("t4_rsp_overflow", 32'(vif0.rsp_overflow), 32'd1);
      chk("t4_rsp_result", 32'(vif0.rsp_result), 32'h0001);
      respond();
      chk("t4_ovf_cnt", 32'(vif0.ovf_cnt), 32'(STAT_ONE));
      chk("t4_grant_cnt0", 32'(vif0.grant_cnt0), 32'(STAT_ONE));
      chk("t4_grant_cnt1", 32'(vif0.grant_cnt1), 32'd0);

      // Reset while in EXEC drops the operation
      vif0.req0_op = 2'b10; vif0.req0_num1 = 16'h1234; vif0.req0_num2 = 16'h0001;
      vif0.req0_valid = 1'b1;
      wait_grant(who);
      @(posedge clk); #1;
      vif0.req0_valid = 1'b0;
      chk("t5_busy_exec", 32'(vif0.busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_busy_rst", 32'(vif0.busy), 32'd0);
      chk("t5_rsp_valid_rst", 32'(vif0.rsp_valid), 32'd0);
      chk("t5_dp_num1_rst", 32'(vif0.dp_num1), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (6) begin
         @(negedge clk);
         saw = saw | vif0.rsp_valid;
      end
      chk("t5_no_response", 32'(saw), 32'd0);
      vif0.req0_op = 2'b10; vif0.req0_num1 = 16'h1111; vif0.req0_num2 = 16'h2222;
      vif0.req1_op = 2'b10; vif0.req1_num1 = 16'h0F00; vif0.req1_num2 = 16'h00F0;
      @(posedge clk); #1;
      vif0.req0_valid = 1'b1;
      vif0.req1_valid = 1'b1;
      wait_grant(who);
      chk("t5_tie_to_req0", 32'(who), 32'd0);
      @(posedge clk); #1;
      vif0.req0_valid = 1'b0;
      vif0.req1_valid = 1'b0;
      wait_rsp(lat);
      chk("t5_rsp_result", 32'(vif0.rsp_result), 32'h3333);
      respond();

      // Latency at SETTLE_CYCLES = 1 and 15
      vif1.req0_op  = 2'b10; vif1.req0_num1  = 16'h0005; vif1.req0_num2  = 16'h0007;
      vif15.req0_op = 2'b10; vif15.req0_num1 = 16'h0005; vif15.req0_num2 = 16'h0007;
      vif1.req0_valid  = 1'b1;
      vif15.req0_valid = 1'b1;
      @(negedge clk);
      chk("t6_ready_s1", 32'(vif1.req0_ready), 32'd1);
      chk("t6_ready_s15", 32'(vif15.req0_ready), 32'd1);
      n = 0; lat1 = 0; lat15 = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            vif1.req0_valid  = 1'b0;
            vif15.req0_valid = 1'b0;
         end
         if (lat1 == 0 && vif1.rsp_valid) lat1 = n;
         if (lat15 == 0 && vif15.rsp_valid) lat15 = n;
      end while ((lat1 == 0 || lat15 == 0) && n < 40);
      chk("t6_latency_s1", 32'(lat1), 32'd2);
      chk("t6_latency_s15", 32'(lat15), 32'd16);
      chk("t6_result_s1", 32'(vif1.rsp_result), 32'h000C);
      chk("t6_result_s15", 32'(vif15.rsp_result), 32'h000C);
      chk("t6_grant_cnt0_s1", 32'(vif1.grant_cnt0), 32'(STAT_ONE));
      chk("t6_grant_cnt1_s15", 32'(vif15.grant_cnt1), 32'd0);
      chk("t6_ovf_cnt_s15", 32'(vif15.ovf_cnt), 32'd0);
      vif1.rsp_ready  = 1'b1;
      vif15.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("t6_hs_s1", 32'(vif1.rsp_valid), 32'd0);
      chk("t6_hs_s15", 32'(vif15.rsp_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
